// File: rtl/branch_update_queue_if.sv
// rtl/branch_update_queue_if.sv - result-in / predictor-update-out bundle for branch_update_queue
interface branch_update_queue_if #(
    parameter int DEPTH   = 4,
    parameter int WAYS    = 2,
    parameter int INDEX_W = 9,
    parameter int TAG_W   = 19
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_pc;
    logic [31:0]        res_new_pc;
    logic               res_taken;
    logic               res_is_branch;
    logic               res_is_return;
    logic               res_is_call;
    logic               res_pred_used;
    logic [1:0]         res_pred_meta;
    logic [WAYS-1:0]    res_update_way;

    logic               upd_stall;
    logic [INDEX_W-1:0] upd_index;
    logic [TAG_W-1:0]   upd_tag;
    logic [1:0]         upd_meta;
    logic               upd_is_branch;
    logic               upd_is_return;
    logic               upd_is_call;
    logic [31:0]        upd_target;
    logic [WAYS-1:0]    upd_tag_we;
    logic [WAYS-1:0]    upd_target_we;

    logic [CNT_W-1:0]   count;

    modport master (
        output res_valid, res_pc, res_new_pc, res_taken, res_is_branch, res_is_return,
               res_is_call, res_pred_used, res_pred_meta, res_update_way, upd_stall,
        input  res_ready, upd_index, upd_tag, upd_meta, upd_is_branch, upd_is_return,
               upd_is_call, upd_target, upd_tag_we, upd_target_we, count
    );

    modport slave (
        input  res_valid, res_pc, res_new_pc, res_taken, res_is_branch, res_is_return,
               res_is_call, res_pred_used, res_pred_meta, res_update_way, upd_stall,
        output res_ready, upd_index, upd_tag, upd_meta, upd_is_branch, upd_is_return,
               upd_is_call, upd_target, upd_tag_we, upd_target_we, count
    );
endinterface

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order queue of resolved branches draining into predictor table writes
module branch_update_queue #(
    parameter int DEPTH   = 4,
    parameter int WAYS    = 2,
    parameter int INDEX_W = 9,
    parameter int TAG_W   = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_update_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Only the pc slices the predictor uses are kept; the rest of the pc is dropped at enqueue.
    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [31:0]        new_pc;
        logic               taken;
        logic               is_branch;
        logic               is_return;
        logic               is_call;
        logic               pred_used;
        logic [1:0]         pred_meta;
        logic [WAYS-1:0]    way;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    entry_t             in_entry;
    entry_t             head;
    logic               head_valid;
    logic               push;
    logic               pop;
    logic [1:0]         meta_next;
    logic               dir_changed;

    wire unused_pc_bits = &{1'b0, bus.res_pc[1:0], bus.res_pc[31:INDEX_W+2+TAG_W]};

    assign in_entry = '{
        index:     bus.res_pc[2 +: INDEX_W],
        tag:       bus.res_pc[INDEX_W+2 +: TAG_W],
        new_pc:    bus.res_new_pc,
        taken:     bus.res_taken,
        is_branch: bus.res_is_branch,
        is_return: bus.res_is_return,
        is_call:   bus.res_is_call,
        pred_used: bus.res_pred_used,
        pred_meta: bus.res_pred_meta,
        way:       bus.res_update_way
    };

    // Ready reflects the registered count only, so a pop never opens a slot in the same cycle.
    assign bus.res_ready = (count_q != FULL_CNT);
    assign head_valid    = (count_q != '0);
    assign push          = bus.res_valid && bus.res_ready;
    assign pop           = head_valid && !bus.upd_stall;
    assign head          = mem[rd_ptr];

    // Entry storage: contents need no reset because nothing strobes while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Two-bit counter update: unpredicted results seed a strong state, predicted ones step and saturate.
    always_comb begin
        meta_next = 2'b00;
        if (!head.pred_used) begin
            meta_next = head.taken ? 2'b11 : 2'b00;
        end else if (head.taken) begin
            meta_next = (head.pred_meta == 2'b11) ? 2'b11 : head.pred_meta + 2'd1;
        end else begin
            meta_next = (head.pred_meta == 2'b00) ? 2'b00 : head.pred_meta - 2'd1;
        end
    end

    // The target bank is only rewritten when the entry is new or its predicted direction flips.
    assign dir_changed = !head.pred_used || (head.pred_meta[1] ^ meta_next[1]);

    assign bus.upd_index     = head.index;
    assign bus.upd_tag       = head.tag;
    assign bus.upd_meta      = meta_next;
    assign bus.upd_is_branch = head.is_branch;
    assign bus.upd_is_return = head.is_return;
    assign bus.upd_is_call   = head.is_call;
    assign bus.upd_target    = head.new_pc;
    assign bus.upd_tag_we    = pop ? head.way : '0;
    assign bus.upd_target_we = bus.upd_tag_we & {WAYS{dir_changed}};
    assign bus.count         = count_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - scoreboard bench for branch_update_queue
module tb_branch_update_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    branch_update_queue_if #(.DEPTH(4), .WAYS(2), .INDEX_W(9), .TAG_W(19)) bus();

    branch_update_queue #(.DEPTH(4), .WAYS(2), .INDEX_W(9), .TAG_W(19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [8:0]  idx;
        logic [18:0] tag;
        logic [1:0]  meta;
        logic        br;
        logic        rt;
        logic        cl;
        logic [31:0] tgt;
        logic [1:0]  tag_we;
        logic [1:0]  tgt_we;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   stall_mode = 0;
    logic stall_fixed = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: derive the table update from the result fields using plain arithmetic.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] npc, input logic tk,
                                   input logic br, input logic rt, input logic cl, input logic pu,
                                   input logic [1:0] pm, input logic [1:0] way);
        exp_t e;
        int   m;
        int   nm;
        bit   dir;
        m = int'(pm);
        if (!pu)      nm = tk ? 3 : 0;
        else if (tk)  nm = (m < 3) ? m + 1 : 3;
        else          nm = (m > 0) ? m - 1 : 0;
        dir = !pu || ((m >= 2) != (nm >= 2));
        e.idx    = 9'((pc >> 2) % 512);
        e.tag    = 19'((pc >> 11) % 524288);
        e.meta   = 2'(nm);
        e.br     = br;
        e.rt     = rt;
        e.cl     = cl;
        e.tgt    = npc;
        e.tag_we = way;
        e.tgt_we = dir ? way : 2'b00;
        return e;
    endfunction

    // Scoreboard push side: record accepted results and track occupancy at each edge.
    always @(posedge clk) begin
        int acc;
        int pp;
        if (!rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            pp  = (model_cnt != 0 && !bus.upd_stall) ? 1 : 0;
            acc = (bus.res_valid && bus.res_ready) ? 1 : 0;
            if (acc != 0) begin
                exp_q.push_back(model(bus.res_pc, bus.res_new_pc, bus.res_taken, bus.res_is_branch,
                                      bus.res_is_return, bus.res_is_call, bus.res_pred_used,
                                      bus.res_pred_meta, bus.res_update_way));
            end
            model_cnt = model_cnt + acc - pp;
        end
    end

    // Monitor: away from the edge, compare ready/count and every drained entry against the scoreboard.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst) begin
            checks++;
            if (bus.res_ready !== (model_cnt != DEPTH)) begin
                errors++;
                $display("FAIL res_ready: got %b want %b (t=%0t)", bus.res_ready, (model_cnt != DEPTH), $time);
            end
            checks++;
            if (bus.count !== 3'(model_cnt)) begin
                errors++;
                $display("FAIL count: got %0d want %0d (t=%0t)", bus.count, model_cnt, $time);
            end
            got = {bus.upd_index, bus.upd_tag, bus.upd_meta, bus.upd_is_branch, bus.upd_is_return,
                   bus.upd_is_call, bus.upd_target, bus.upd_tag_we, bus.upd_target_we};
            if (model_cnt != 0 && !bus.upd_stall && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL drain: got %h want %h (t=%0t)", got, want, $time);
                end
            end else begin
                checks++;
                if (bus.upd_tag_we !== 2'b00 || bus.upd_target_we !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_strobe: got tag_we=%b target_we=%b want 00/00 (t=%0t)",
                             bus.upd_tag_we, bus.upd_target_we, $time);
                end
            end
        end
    end

    // Stall generator: fixed level, toggling every cycle, or random.
    always @(posedge clk) begin
        #1;
        case (stall_mode)
            1:       bus.upd_stall = ~bus.upd_stall;
            2:       bus.upd_stall = ($urandom_range(0, 2) == 0);
            default: bus.upd_stall = stall_fixed;
        endcase
    end

    task automatic set_res(input logic [31:0] pc, input logic [31:0] npc, input logic tk, input logic pu,
                           input logic [1:0] pm, input logic [1:0] way);
        bus.res_pc         = pc;
        bus.res_new_pc     = npc;
        bus.res_taken      = tk;
        bus.res_is_branch  = $urandom_range(0, 1);
        bus.res_is_return  = $urandom_range(0, 1);
        bus.res_is_call    = $urandom_range(0, 1);
        bus.res_pred_used  = pu;
        bus.res_pred_meta  = pm;
        bus.res_update_way = way;
    endtask

    // Offer one result and hold it until the handshake completes, within a cycle budget.
    task automatic send(input logic [31:0] pc, input logic [31:0] npc, input logic tk, input logic pu,
                        input logic [1:0] pm, input logic [1:0] way);
        bit acc;
        int budget;
        set_res(pc, npc, tk, pu, pm, way);
        bus.res_valid = 1'b1;
        acc = 1'b0;
        budget = 40;
        while (!acc && budget > 0) begin
            @(posedge clk);
            acc = bus.res_valid && bus.res_ready;
            budget--;
            #1;
        end
        bus.res_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no handshake want accept pc=%h", pc);
        end
    endtask

    task automatic send_rand();
        send($urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_empty();
        int budget;
        budget = 60;
        while (model_cnt != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (model_cnt != 0) begin
            errors++;
            $display("FAIL drain_timeout: got occupancy %0d want 0", model_cnt);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.res_valid = 1'b0;
        bus.upd_stall = 1'b0;
        set_res('0, '0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(2);
        rst = 1'b1;
        idle(2);

        // Single predicted result, then unpredicted and saturated entries.
        send(32'h0000_1A44, 32'h0000_2000, 1'b1, 1'b1, 2'b01, 2'b01);
        wait_empty();
        send(32'h0000_3210, 32'h0000_4000, 1'b1, 1'b0, 2'b00, 2'b10);
        send(32'h0000_3214, 32'h0000_4400, 1'b1, 1'b1, 2'b11, 2'b10);
        wait_empty();

        // Fill while stalled: the fifth result must wait for a slot.
        stall_fixed = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(i * 4), 32'h8000 + 32'(i), 1'b0, 1'b1, 2'(i), 2'b11);
        set_res(32'h0000_0200, 32'h0000_9000, 1'b1, 1'b1, 2'b10, 2'b01);
        bus.res_valid = 1'b1;
        idle(3);
        stall_fixed = 1'b0;
        idle(1);
        bus.res_valid = 1'b0;
        wait_empty();

        // Stream with stall toggling every cycle to exercise pointer wrap.
        stall_mode = 1;
        for (int i = 0; i < 10; i++) send_rand();
        wait_empty();
        stall_mode = 0;
        stall_fixed = 1'b0;
        idle(2);

        // Reset with entries queued, then resume normal operation.
        stall_fixed = 1'b1;
        idle(1);
        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        stall_fixed = 1'b0;
        idle(3);
        send(32'h0000_0A40, 32'h0000_0B00, 1'b0, 1'b1, 2'b10, 2'b01);
        wait_empty();

        // Randomized traffic with random stalls and gaps.
        stall_mode = 2;
        for (int i = 0; i < 200; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        stall_mode = 0;
        stall_fixed = 1'b0;
        idle(1);
        wait_empty();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
